// File: rtl/input_debouncer_if.sv
// Signal bundle between a bouncy raw input source and its debouncer.
// The master drives d_raw and consumes the conditioned outputs.
interface input_debouncer_if;
    logic d_raw;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d_raw,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d_raw,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous input and accepts a new level only after it
// holds for DEBOUNCE_CYCLES clocks; emits the clean level plus edge pulses.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input logic             clk,
    input logic             rst_n,
    input_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("input_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if ((longint'(1) << CNT_W) < longint'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("input_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.d_raw};
    assign s      = sync_q[SYNC_STAGES-1];

    // A WAIT state falls back to its STABLE origin the moment s disagrees.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = busy_q;

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions one asynchronous, bouncy input (push-button or switch) into a clean, clk-synchronous level for the downstream D flip-flop and latch stages.
- Synchronizes the raw input through a flip-flop chain.
- Rejects any level change that does not hold stable for DEBOUNCE_CYCLES consecutive clocks.
- Emits single-cycle rise and fall pulses alongside the debounced level.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flip-flops (legal range 2..4).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a new level (>=1).
- CNT_W, 16, debounce counter width; 2^CNT_W >= DEBOUNCE_CYCLES is required (elaboration-time check).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  reset, synchronous, active-low.
- d_raw  input  1  asynchronous raw input.
- q  output  1  debounced level, registered; drives the downstream d input.
- rise  output  1  one-cycle pulse, coincident with q going 0->1.
- fall  output  1  one-cycle pulse, coincident with q going 1->0.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (rst_n==0 at a posedge) has priority over all other activity. It clears:
  - sync chain to all 0
  - state to STABLE_LO
  - cnt to 0
  - q, rise, fall, busy to 0
- Reset mid-qualification abandons the candidate with no pulse. Reset while q==1 drops q to 0 with no fall pulse.
- Synchronizer: sync[0] <= d_raw and sync[i] <= sync[i-1]; s = sync[SYNC_STAGES-1]. Only s is used by the FSM; d_raw never reaches the FSM directly.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if s==1, go to WAIT_HI with cnt <= 0; otherwise stay.
  - WAIT_HI:
    - s==0: return to STABLE_LO with cnt <= 0 (glitch rejected, no output change).
    - s==1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, q <= 1, rise <= 1, cnt <= 0.
    - otherwise: cnt <= cnt+1.
  - STABLE_HI and WAIT_LO mirror the above with inverted s, q <= 0 and fall <= 1.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- rise and fall are registered and high for exactly one cycle. They are never high together and never high in reset.
- busy is a registered decode: 1 exactly when the state is WAIT_HI or WAIT_LO.
- Latency: number edges from the first posedge that samples d_raw at its new, held value as edge 1. q changes at edge SYNC_STAGES + DEBOUNCE_CYCLES + 1. With defaults that is edge 7. busy rises at edge SYNC_STAGES+1.
- A level change on s in the same cycle that qualification completes is impossible by construction: completion requires s at the new level.
- Bounce in a STABLE state with a pulse shorter than DEBOUNCE_CYCLES produces a WAIT excursion (busy pulse) only. q, rise and fall are unaffected.
- DEBOUNCE_CYCLES==1: q changes one cycle after entering WAIT, provided s holds.
- Outputs are fully synchronous to clk and safe to feed directly into downstream posedge or negedge capture.

Test Plan:
Defaults throughout: SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset: rst_n=0 for 3 edges with d_raw=1 -> q, rise, fall, busy all 0 during reset; first edge after release q still 0; q rises 7 edges after release.
2. Clean press: d_raw 0->1 before edge 1, held -> busy=1 after edge 3; q=1 and rise=1 after edge 7; rise=0 after edge 8; busy=0 after edge 7.
3. Glitch reject: d_raw=1 for 3 edges then 0 -> busy pulses, q stays 0, rise never asserts, state returns to STABLE_LO.
4. Release: from q=1, d_raw 1->0 held -> q=0 and fall=1 after edge 7, fall=0 after edge 8, rise stays 0.
5. Reset mid-qualification: press as in scenario 2, rst_n=0 at edge 5 -> q=0 and busy=0 after edge 5; release reset with d_raw=1 -> q rises 7 edges after release.
6. Bounce: d_raw toggles every 2 cycles for 20 cycles, then held at 1 -> exactly one rise pulse total, no fall pulse, final q=1.
